// File: rtl/iz_sched_pkg.sv
// Shared types and constants for the Izhikevich parameter scheduler:
// state encoding, frame geometry and the loader's reset parameter values.
package iz_sched_pkg;

   localparam int PARAM_W = 6;
   localparam int FRAME_W = 24;

   localparam int A_OFS = 18;
   localparam int B_OFS = 12;
   localparam int C_OFS = 6;
   localparam int D_OFS = 0;

   localparam logic [PARAM_W-1:0] A_DEF = 6'd13;
   localparam logic [PARAM_W-1:0] B_DEF = 6'd13;
   localparam logic [PARAM_W-1:0] C_DEF = 6'd31;
   localparam logic [PARAM_W-1:0] D_DEF = 6'd8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRE      = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_WAIT_RDY = 3'd3,
      ST_GAP      = 3'd4
   } sched_state_e;

   function automatic logic [FRAME_W-1:0] pack_frame(
      input logic [PARAM_W-1:0] a,
      input logic [PARAM_W-1:0] b,
      input logic [PARAM_W-1:0] c,
      input logic [PARAM_W-1:0] d
   );
      logic [FRAME_W-1:0] f;
      f = '0;
      f[A_OFS +: PARAM_W] = a;
      f[B_OFS +: PARAM_W] = b;
      f[C_OFS +: PARAM_W] = c;
      f[D_OFS +: PARAM_W] = d;
      return f;
   endfunction

endpackage

// File: rtl/iz_rr_arbiter.sv
// Requester selection: round-robin search from pointer+1, or fixed lowest-index
// priority when IZ_SCHED_PRIORITY_EN is defined (no pointer in that build).
module iz_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_update,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] w_cand;

`ifdef IZ_SCHED_PRIORITY_EN
   // Lowest set request bit wins.
   always_comb begin
      o_any  = 1'b0;
      o_idx  = '0;
      o_gnt  = '0;
      w_cand = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = IDX_W'(k);
         if (!o_any && i_req[w_cand]) begin
            o_any = 1'b1;
            o_idx = w_cand;
         end else begin
            o_any = o_any;
         end
      end
      if (o_any) begin
         o_gnt[o_idx] = 1'b1;
      end else begin
         o_gnt = '0;
      end
   end
`else
   logic [IDX_W-1:0] r_ptr;

   // Pointer remembers the last winner; reset value makes requester 0 win first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= IDX_W'(N_REQ - 1);
      end else if (i_update && o_any) begin
         r_ptr <= o_idx;
      end else begin
         r_ptr <= r_ptr;
      end
   end

   // First set bit searching upward from pointer+1 with wrap-around.
   always_comb begin
      o_any  = 1'b0;
      o_idx  = '0;
      o_gnt  = '0;
      w_cand = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         w_cand = IDX_W'((int'(r_ptr) + off) % N_REQ);
         if (!o_any && i_req[w_cand]) begin
            o_any = 1'b1;
            o_idx = w_cand;
         end else begin
            o_any = o_any;
         end
      end
      if (o_any) begin
         o_gnt[o_idx] = 1'b1;
      end else begin
         o_gnt = '0;
      end
   end
`endif

endmodule

// File: rtl/iz_param_scheduler.sv
// Arbitrates N_REQ requesters onto one Izhikevich parameter serial loader.
// Build option: IZ_SCHED_PRIORITY_EN selects fixed priority instead of round-robin.
module iz_param_scheduler
   import iz_sched_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int GAP_CYC     = 2,
   parameter int TIMEOUT_CYC = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [FRAME_W*N_REQ-1:0] req_params,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         done,
   output logic                     ld_enable,
   output logic                     ld_serial,
   output logic                     ld_load_enable,
   input  logic                     ld_params_ready,
   output logic                     busy,
   output logic                     timeout_err,
   input  logic                     clr_err
);

   localparam int IDX_W    = $clog2(N_REQ);
   localparam int WAIT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   sched_state_e       r_state, w_nxt_state;
   logic [4:0]         r_bit_cnt, w_nxt_bit_cnt, w_bit_idx;
   logic [WAIT_W-1:0]  r_wait_cnt, w_nxt_wait_cnt;
   logic [FRAME_W-1:0] r_shadow, w_sel_frame;
   logic [N_REQ-1:0]   r_gnt, r_done, w_arb_gnt;
   logic [IDX_W-1:0]   w_arb_idx;
   logic               w_arb_any, w_grant, w_finish, w_tmo_hit;
   logic               w_nxt_load_en, w_nxt_serial;
   logic               r_ld_enable, r_ld_serial, r_ld_load_enable, r_busy, r_timeout_err;

   iz_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (req),
      .i_update (w_grant),
      .o_gnt    (w_arb_gnt),
      .o_idx    (w_arb_idx),
      .o_any    (w_arb_any)
   );

   // One-hot frame mux from the arbiter's grant vector.
   always_comb begin
      w_sel_frame = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sel_frame = w_sel_frame | ({FRAME_W{w_arb_gnt[k]}} & req_params[FRAME_W*k +: FRAME_W]);
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 5'd0;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_bit_cnt  <= w_nxt_bit_cnt;
         r_wait_cnt <= w_nxt_wait_cnt;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_bit_cnt  = r_bit_cnt;
      w_nxt_wait_cnt = r_wait_cnt;
      w_grant        = 1'b0;
      w_finish       = 1'b0;
      w_tmo_hit      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_any) begin
               w_grant     = 1'b1;
               w_nxt_state = ST_PRE;
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_PRE: begin
            w_nxt_state   = ST_SHIFT;
            w_nxt_bit_cnt = 5'd0;
         end
         ST_SHIFT: begin
            if (r_bit_cnt == 5'(FRAME_W - 1)) begin
               w_nxt_state    = ST_WAIT_RDY;
               w_nxt_wait_cnt = '0;
            end else begin
               w_nxt_bit_cnt = r_bit_cnt + 5'd1;
            end
         end
         ST_WAIT_RDY: begin
            if (ld_params_ready) begin
               w_finish       = 1'b1;
               w_nxt_state    = ST_GAP;
               w_nxt_wait_cnt = '0;
            end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
               w_tmo_hit      = 1'b1;
               w_finish       = 1'b1;
               w_nxt_state    = ST_GAP;
               w_nxt_wait_cnt = '0;
            end else begin
               w_nxt_wait_cnt = r_wait_cnt + WAIT_W'(1);
            end
         end
         ST_GAP: begin
            if (r_wait_cnt == WAIT_W'(GAP_CYC - 1)) begin
               w_nxt_state = ST_IDLE;
            end else begin
               w_nxt_wait_cnt = r_wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   // Loader pin values for the upcoming cycle, decoded from the next state so
   // the registered pins line up with the state they belong to.
   always_comb begin
      w_nxt_load_en = (w_nxt_state == ST_PRE) || (w_nxt_state == ST_SHIFT);
      w_bit_idx     = 5'(FRAME_W - 1) - w_nxt_bit_cnt;
      if (w_nxt_state == ST_SHIFT) begin
         w_nxt_serial = r_shadow[w_bit_idx];
      end else begin
         w_nxt_serial = 1'b0;
      end
   end

   // Registered outputs, shadow frame and sticky error (set beats clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow         <= '0;
         r_gnt            <= '0;
         r_done           <= '0;
         r_ld_enable      <= 1'b0;
         r_ld_serial      <= 1'b0;
         r_ld_load_enable <= 1'b0;
         r_busy           <= 1'b0;
         r_timeout_err    <= 1'b0;
      end else begin
         r_ld_enable      <= 1'b1;
         r_ld_serial      <= w_nxt_serial;
         r_ld_load_enable <= w_nxt_load_en;
         r_busy           <= (w_nxt_state != ST_IDLE);
         r_done           <= w_finish ? r_gnt : '0;
         if (w_grant) begin
            r_shadow <= w_sel_frame;
            r_gnt    <= w_arb_gnt;
         end else if (w_finish) begin
            r_gnt <= '0;
         end else begin
            r_gnt <= r_gnt;
         end
         if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
         end else if (clr_err) begin
            r_timeout_err <= 1'b0;
         end else begin
            r_timeout_err <= r_timeout_err;
         end
      end
   end

   assign gnt            = r_gnt;
   assign done           = r_done;
   assign ld_enable      = r_ld_enable;
   assign ld_serial      = r_ld_serial;
   assign ld_load_enable = r_ld_load_enable;
   assign busy           = r_busy;
   assign timeout_err    = r_timeout_err;

endmodule

// File: doc/iz_param_scheduler.md
Name: iz_param_scheduler

Overview:
- Shares one Izhikevich parameter serial loader among N_REQ requesters, such as a host config port, a learning engine or a test sequencer.
- Round-robin arbitration picks one requester at a time.
- The scheduler latches that requester's 24-bit parameter frame (a, b, c, d, 6 bits each) and serialises it onto the loader's serial/load_enable pins with the required preamble.
- It then waits for the loader's params_ready, acknowledges the requester and enforces an inter-frame gap.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYC, 2, load_enable-low cycles between frames (min 1).
- TIMEOUT_CYC, 8, max cycles waiting for ld_params_ready before flagging an error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- req_params  in  24*N_REQ  requester k frame at [24k+23:24k]; packing {a,b,c,d}, a in [23:18].
- gnt  out  N_REQ  one-hot grant, held from grant until done.
- done  out  N_REQ  one-cycle completion pulse to the granted requester.
- ld_enable  out  1  loader enable.
- ld_serial  out  1  loader serial data.
- ld_load_enable  out  1  loader load_enable.
- ld_params_ready  in  1  loader params_ready.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky error flag.
- clr_err  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset values: gnt=0, done=0, ld_enable=0, ld_serial=0, ld_load_enable=0, busy=0, timeout_err=0. State goes to IDLE and the round-robin pointer to N_REQ-1 (so requester 0 wins first).
- ld_enable is registered and goes to 1 on the first clock after reset release; it stays 1.
- All loader-facing outputs are registered, with no combinational path from inputs.
- IDLE:
  - If any req bit is set, choose the first set bit searching upward from pointer+1 (wrapping).
  - Register gnt, copy that requester's frame into a 24-bit shadow register, update the pointer, go to PRE.
  - With no requests, stay in IDLE.
- PRE (1 cycle): ld_load_enable=1, ld_serial=0. This creates the rising edge the loader needs to enter its load sequence. The loader ignores data in this cycle.
- SHIFT (24 cycles): ld_load_enable=1. In SHIFT cycle i (0..23), ld_serial = shadow[23-i], i.e. MSB of a first and LSB of d last. A 5-bit counter tracks i. After i=23, go to WAIT_RDY.
- WAIT_RDY:
  - ld_load_enable=0.
  - When ld_params_ready=1: pulse done[k] for 1 cycle, clear gnt on the same edge, go to GAP. In a healthy system this is the first WAIT_RDY cycle.
  - If TIMEOUT_CYC cycles pass without ld_params_ready: set timeout_err, still pulse done[k], go to GAP.
- GAP: ld_load_enable=0 for GAP_CYC cycles, then IDLE. This guarantees a clean rising edge for the next preamble.
- Total latency from grant edge to done pulse: 1 + 24 + 1 = 26 cycles nominal.
- Requester rules:
  - req_params is sampled only at grant; later changes are ignored.
  - Deasserting req after grant does not abort the frame; done still pulses.
  - Requester k must drop req on the cycle after done, or it rejoins arbitration. Round-robin still serves others first.
- Simultaneous requests are resolved by round-robin. A requester never waits more than N_REQ-1 frames.
- clr_err and a new timeout in the same cycle: set wins.
- Asserting rst_n mid-frame immediately drives all outputs to reset values. The loader sees load_enable fall and returns to IDLE through its own READY/IDLE path; the partial frame is discarded.

Optional Feature:
- Macro IZ_SCHED_PRIORITY_EN.
- Defined: fixed priority replaces round-robin; the lowest index wins and the pointer logic is removed. Everything else is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Package iz_sched_pkg holds:
  - the state encoding (IDLE, PRE, SHIFT, WAIT_RDY, GAP);
  - PARAM_W=6, FRAME_W=24;
  - field offsets A_OFS=18, B_OFS=12, C_OFS=6, D_OFS=0;
  - default constants matching the loader reset values (13, 13, 31, 8).
- One natural sub-module, iz_rr_arbiter: req vector plus pointer in, one-hot grant out. It is combinational search plus a registered pointer, and holds the IZ_SCHED_PRIORITY_EN switch.

Test Plan:
- Single request: req=4'b0001, frame {a=6'd20, b=6'd5, c=6'd40, d=6'd3}. Required response:
  - ld_serial bit stream over 24 SHIFT cycles = 010100 000101 101000 000011;
  - loader model outputs those exact values;
  - done[0] pulses 26 cycles after grant.
- Contention: req=4'b1111 held, each requester dropping req after its done. Grant order must be 0, 1, 2, 3, with ld_load_enable low for ≥2 cycles between frames.
- Fairness: req0 re-asserts immediately while req2 is pending. Order must be 0, 2, 0, not 0, 0.
- Timeout: loader model keeps ld_params_ready=0. After 8 WAIT_RDY cycles, timeout_err=1 and done pulses. Then clr_err=1 clears the flag.
- Reset mid-SHIFT at bit 10: all outputs 0 immediately. After reset release, a new request loads the full frame correctly.
- With IZ_SCHED_PRIORITY_EN defined and req=4'b0110 held: requester 1 is always granted before 2.
